// File: rtl/regfile_pkg.sv
// Shared register-file widths and the write-arbiter state encoding,
// used by both regfile_wr_arb and regfile.
package regfile_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int NREGS  = 8;
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regfile.sv
// 8 x 8 register file with one synchronous write port and one combinational
// read port; driven from the rf_* outputs of regfile_wr_arb.
module regfile
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NREGS];

  // NOTE: the storage array is deliberately not reset; its contents are only
  // meaningful once written, and a reset port would stop it mapping to RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/regfile_wr_arb.sv
// Two-requester write arbiter for the register file: round-robin from idle,
// sticky ownership bounded by MAX_BURST, registered write port (1-cycle latency).
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  arb_state_t        state;
  arb_state_t        state_next;
  logic              rr_ptr;
  logic [CNT_W-1:0]  burst_cnt;

  logic              win_valid;
  logic              win_sel;
  logic              owner_change;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Winner selection: the owner keeps the port until its burst budget is
  // spent, but only while the other side actually has something to write.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    win_valid = 1'b0;
    win_sel   = 1'b0;
    case (state)
      OWN0: begin
        if (req0_valid && ((burst_cnt < BURST_LIM) || !req1_valid)) begin
          win_valid = 1'b1;
          win_sel   = 1'b0;
        end else if (req1_valid) begin
          win_valid = 1'b1;
          win_sel   = 1'b1;
        end
      end
      OWN1: begin
        if (req1_valid && ((burst_cnt < BURST_LIM) || !req0_valid)) begin
          win_valid = 1'b1;
          win_sel   = 1'b1;
        end else if (req0_valid) begin
          win_valid = 1'b1;
          win_sel   = 1'b0;
        end
      end
      default: begin
        if (req0_valid && req1_valid) begin
          win_valid = 1'b1;
          win_sel   = rr_ptr;
        end else if (req0_valid) begin
          win_valid = 1'b1;
          win_sel   = 1'b0;
        end else if (req1_valid) begin
          win_valid = 1'b1;
          win_sel   = 1'b1;
        end
      end
    endcase
  end

  assign owner_change = (state == IDLE) ||
                        (win_sel ? (state != OWN1) : (state != OWN0));

  assign state_next = !win_valid ? IDLE : (win_sel ? OWN1 : OWN0);

  assign win_addr = win_sel ? req1_addr : req0_addr;
  assign win_data = win_sel ? req1_data : req0_data;

  // Grants are gated by reset so no handshake can be seen while it is held.
  assign req0_ready = rst && win_valid && !win_sel;
  assign req1_ready = rst && win_valid &&  win_sel;

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      state <= state_next;
      rf_we <= win_valid;
      if (win_valid) begin
        rr_ptr   <= ~win_sel;
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
        if (owner_change) begin
          burst_cnt <= CNT_W'(1);
        end else if (burst_cnt != CNT_MAX) begin
          burst_cnt <= burst_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb: a table of per-cycle vectors plus
// hand-written burst, saturation and mid-cycle reset sequences.
module tb_regfile_wr_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0;
  logic [2:0] req0_addr  = '0;
  logic [7:0] req0_data  = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [2:0] req1_addr  = '0;
  logic [7:0] req1_data  = '0;
  logic       req1_ready;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       busy;
  logic [2:0] rd_addr = '0;
  logic [7:0] rd_data;

  int total = 0;
  int bad   = 0;

  regfile_wr_arb #(.MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy)
  );

  regfile u_rf (
    .clk   (clk),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [7:0] d1);
    req0_valid = v0;
    req0_addr  = a0;
    req0_data  = d0;
    req1_valid = v1;
    req1_addr  = a1;
    req1_data  = d1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic       v0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       bsy;
  } vec_t;

  vec_t vecs [10];
  int   pat  [12];

  initial begin
    // inputs (v0 a0 d0 v1 a1 d1) | expected (r0 r1 we waddr wdata busy)
    // Registered outputs reflect the transfer of the previous row.
    vecs[0] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 3'd1, 8'hAA, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'hAA, 1'b1};
    vecs[3] = '{1'b1, 3'd2, 8'h55, 1'b1, 3'd3, 8'h33, 1'b0, 1'b1, 1'b0, 3'd1, 8'hAA, 1'b0};
    vecs[4] = '{1'b1, 3'd2, 8'h55, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h33, 1'b1};
    vecs[5] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h55, 1'b1};
    vecs[6] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 8'h55, 1'b0};
    vecs[7] = '{1'b1, 3'd4, 8'h44, 1'b1, 3'd5, 8'h77, 1'b0, 1'b1, 1'b0, 3'd2, 8'h55, 1'b0};
    vecs[8] = '{1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'h77, 1'b1};
    vecs[9] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h44, 1'b1};

    pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    // Reset state, with both requesters asserting valid during reset.
    drive(1'b1, 3'd7, 8'hFF, 1'b1, 3'd6, 8'hEE);
    @(negedge clk);
    #1;
    check("rst ready0", req0_ready, 1'b0);
    check("rst ready1", req1_ready, 1'b0);
    check("rst rf_we", rf_we, 1'b0);
    check("rst rf_waddr", rf_waddr, 3'd0);
    check("rst rf_wdata", rf_wdata, 8'h00);
    check("rst busy", busy, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      #1;
      check($sformatf("vec%0d ready0", i), req0_ready, vecs[i].r0);
      check($sformatf("vec%0d ready1", i), req1_ready, vecs[i].r1);
      check($sformatf("vec%0d rf_we", i), rf_we, vecs[i].we);
      check($sformatf("vec%0d rf_waddr", i), rf_waddr, vecs[i].wa);
      check($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].wd);
      check($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
    end

    // Contention straight after reset: req0 first, req1 next, writes back-to-back.
    do_reset();
    @(negedge clk);
    drive(1'b1, 3'd2, 8'h55, 1'b1, 3'd3, 8'h33);
    #1;
    check("c32 first ready0", req0_ready, 1'b1);
    check("c32 first ready1", req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("c32 second ready1", req1_ready, 1'b1);
    check("c32 second ready0", req0_ready, 1'b0);
    check("c32 wr0 we", rf_we, 1'b1);
    check("c32 wr0 addr", rf_waddr, 3'd2);
    check("c32 wr0 data", rf_wdata, 8'h55);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check("c32 wr1 we", rf_we, 1'b1);
    check("c32 wr1 addr", rf_waddr, 3'd3);
    check("c32 wr1 data", rf_wdata, 8'h33);
    @(negedge clk);
    #1;
    check("c32 done we", rf_we, 1'b0);
    rd_addr = 3'd2;
    #1;
    check("rf reg2", rd_data, 8'h55);
    rd_addr = 3'd3;
    #1;
    check("rf reg3", rd_data, 8'h33);

    // Both held valid: bursts of MAX_BURST alternate, one grant per cycle.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b1, 3'd6, 8'h66, 1'b1, 3'd7, 8'h77);
      #1;
      check($sformatf("burst%0d ready0", i), req0_ready, pat[i] == 0);
      check($sformatf("burst%0d ready1", i), req1_ready, pat[i] == 1);
      if (i > 0) begin
        check($sformatf("burst%0d rf_we", i), rf_we, 1'b1);
        check($sformatf("burst%0d rf_waddr", i), rf_waddr, (pat[i-1] == 1) ? 3'd7 : 3'd6);
      end
    end

    // Only req1 valid past counter saturation: never forced out, no bubbles.
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 8'h10 + 8'(i));
      #1;
      check($sformatf("solo%0d ready1", i), req1_ready, 1'b1);
      check($sformatf("solo%0d ready0", i), req0_ready, 1'b0);
      if (i > 0) begin
        check($sformatf("solo%0d rf_we", i), rf_we, 1'b1);
        check($sformatf("solo%0d rf_wdata", i), rf_wdata, 8'h10 + 8'(i - 1));
      end
    end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check("solo last we", rf_we, 1'b1);
    check("solo last data", rf_wdata, 8'h21);
    @(negedge clk);
    #1;
    check("hold we", rf_we, 1'b0);
    check("hold addr", rf_waddr, 3'd1);
    check("hold data", rf_wdata, 8'h21);
    @(negedge clk);
    #1;
    check("hold2 addr", rf_waddr, 3'd1);
    check("hold2 data", rf_wdata, 8'h21);

    // Reset dropped between edges mid-burst, then contention after release.
    @(negedge clk);
    drive(1'b1, 3'd1, 8'h11, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #2;
    check("pre-rst busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mid-rst rf_we", rf_we, 1'b0);
    check("mid-rst busy", busy, 1'b0);
    check("mid-rst ready0", req0_ready, 1'b0);
    check("mid-rst ready1", req1_ready, 1'b0);
    check("mid-rst rf_waddr", rf_waddr, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 3'd4, 8'h44, 1'b1, 3'd5, 8'h55);
    #1;
    check("post-rst ready0", req0_ready, 1'b1);
    check("post-rst ready1", req1_ready, 1'b0);
    check("post-rst rf_we", rf_we, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    #1;
    check("post-rst wr addr", rf_waddr, 3'd4);
    check("post-rst wr data", rf_wdata, 8'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
